// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared types and constants for the USB transmit path: the
//                packetizer state encoding, common PID values and the CRC16
//                parameters plus a byte-wide CRC16 update helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SYNC   = 4'd1,
    ST_PID    = 4'd2,
    ST_DATA   = 4'd3,
    ST_CRC_LO = 4'd4,
    ST_CRC_HI = 4'd5,
    ST_DRAIN  = 4'd6,
    ST_EOP    = 4'd7,
    ST_DONE   = 4'd8
  } tx_state_e;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic logic [15:0] reflect16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = v[15-i];
    end
    return r;
  endfunction

  // USB serialises LSB-first, so the register is kept bit-reflected: bit 0
  // holds the oldest term and the polynomial is applied in mirrored form.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  data);
    logic [15:0] c;
    logic [15:0] poly_r;
    poly_r = reflect16(CRC16_POLY);
    c      = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_crc16.sv
`default_nettype none
// ============================================================================
//  Module      : usb_crc16
//  Description : USB CRC16 accumulator, one byte per update. The output is
//                already complemented and bit-ordered so that crc_out[7:0]
//                is the first CRC byte on the wire.
//  Ports       : clk, n_rst      - clock, async active-low reset
//                clear           - reseed the accumulator
//                update, data    - fold one byte into the CRC
//                crc_out         - complemented CRC of all bytes since clear
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        update,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  localparam logic [15:0] c_seed = reflect16(CRC16_INIT);

  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  assign w_crc_next = crc16_update(r_crc, data);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_crc <= 16'h0000;
    end else if (clear) begin
      r_crc <= c_seed;
    end else if (update) begin
      r_crc <= w_crc_next;
    end
  end

  assign crc_out = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_tx_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_packetizer
//  Description : USB transmit packet controller. Emits SYNC, PID, optional
//                payload pulled from a show-ahead FIFO, CRC16 and EOP, handing
//                each byte to the serial shifter with a one-cycle load strobe.
//  Ports       : clk, n_rst            - clock, async active-low reset
//                tx_start, tx_pid      - packet request and its PID
//                tx_abort              - cut the current packet short
//                fifo_empty/rdata/rd   - show-ahead TX FIFO interface
//                shift_rdy, byte_load,
//                tx_byte               - shifter byte handshake
//                sending, eop          - bus phase indicators
//                tx_done, tx_err       - completion pulse and error status
//                busy                  - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int          MAX_PAYLOAD = 64,
  parameter int          EOP_CYCLES  = 2,
  parameter logic [7:0]  SYNC_BYTE   = 8'h80,
  parameter int          CNT_W       = 7
)
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_abort,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  input  logic       shift_rdy,
  output logic       byte_load,
  output logic [7:0] tx_byte,
  output logic       sending,
  output logic       eop,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam int                 c_eop_w    = $clog2(EOP_CYCLES + 1);
  localparam logic [c_eop_w-1:0] c_eop_last = c_eop_w'(EOP_CYCLES - 1);
  localparam logic [c_eop_w-1:0] c_eop_one  = c_eop_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_max  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

  tx_state_e          r_state;
  tx_state_e          w_state_next;
  logic [3:0]         r_pid;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [c_eop_w-1:0] r_eop_cnt;
  logic [7:0]         r_tx_byte;

  logic               w_has_payload;
  logic [7:0]         w_byte;
  logic               w_start;
  logic               w_err_set;
  logic               w_err_clr;
  logic               w_cnt_inc;
  logic [15:0]        w_crc;

  // DATA0/1/2/MDATA all share the low PID bits 2'b11.
  assign w_has_payload = (r_pid[1:0] == 2'b11);

  usb_crc16 u_crc (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (w_start),
    .update  (w_cnt_inc),
    .data    (fifo_rdata),
    .crc_out (w_crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_pid     <= 4'h0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_eop_cnt <= '0;
      r_tx_byte <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_pid <= tx_pid;
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
      r_eop_cnt <= (r_state == ST_EOP) ? (r_eop_cnt + c_eop_one) : '0;
      if (byte_load) begin
        r_tx_byte <= w_byte;
      end
    end
  end

  // The shifter captures tx_byte in the same cycle as byte_load, so the
  // freshly selected byte bypasses the holding register on load cycles.
  assign tx_byte = byte_load ? w_byte : r_tx_byte;
  assign busy    = (r_state != ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_byte       = 8'h00;
    byte_load    = 1'b0;
    fifo_rd      = 1'b0;
    w_start      = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    sending      = 1'b0;
    eop          = 1'b0;
    tx_done      = 1'b0;
    tx_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_start      = 1'b1;
          w_state_next = ST_SYNC;
        end
      end

      ST_SYNC: begin
        sending = 1'b1;
        w_byte  = SYNC_BYTE;
        if (tx_abort) begin
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (shift_rdy) begin
          byte_load    = 1'b1;
          w_state_next = ST_PID;
        end
      end

      ST_PID: begin
        sending = 1'b1;
        w_byte  = {~r_pid, r_pid};
        if (tx_abort) begin
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (shift_rdy) begin
          byte_load    = 1'b1;
          w_state_next = w_has_payload ? ST_DATA : ST_DRAIN;
        end
      end

      ST_DATA: begin
        sending = 1'b1;
        w_byte  = fifo_rdata;
        if (tx_abort) begin
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (fifo_empty) begin
          w_state_next = ST_CRC_LO;
        end else if (r_cnt == c_cnt_max) begin
          // More data than a packet may carry: drop the CRC so the
          // receiver rejects the packet.
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (shift_rdy) begin
          byte_load = 1'b1;
          fifo_rd   = 1'b1;
          w_cnt_inc = 1'b1;
        end
      end

      ST_CRC_LO: begin
        sending = 1'b1;
        w_byte  = w_crc[7:0];
        if (tx_abort) begin
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (shift_rdy) begin
          byte_load    = 1'b1;
          w_state_next = ST_CRC_HI;
        end
      end

      ST_CRC_HI: begin
        sending = 1'b1;
        w_byte  = w_crc[15:8];
        if (tx_abort) begin
          w_err_set    = 1'b1;
          w_state_next = ST_DRAIN;
        end else if (shift_rdy) begin
          byte_load    = 1'b1;
          w_state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        sending = 1'b1;
        if (shift_rdy) begin
          w_state_next = ST_EOP;
        end
      end

      ST_EOP: begin
        eop = 1'b1;
        if (r_eop_cnt == c_eop_last) begin
          w_state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        tx_done      = 1'b1;
        tx_err       = r_err;
        w_err_clr    = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/usb_tx_packetizer.md
Name: usb_tx_packetizer

Overview:
Parametrised USB transmit packet controller. It builds complete packets for any data or handshake PID: SYNC, PID byte, optional payload, CRC16, then EOP. Payload bytes are pulled from a show-ahead TX FIFO, and each byte is handed to the downstream NRZI/bit-stuff shifter through a one-cycle load handshake. It sits between the SD-side data buffer and the USB serial encoder, and replaces fixed-PID transmit control.

Parameters:
MAX_PAYLOAD, 64, maximum payload bytes per data packet; exceeding it aborts the packet.
EOP_CYCLES, 2, number of clk cycles eop is held high.
SYNC_BYTE, 8'h80, byte value sent as SYNC.
CNT_W, 7, payload counter width; must satisfy 2**CNT_W > MAX_PAYLOAD.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  in  4  PID to send; latched when tx_start is accepted
tx_abort  in  1  terminate the current packet early
fifo_empty  in  1  TX FIFO empty
fifo_rdata  in  8  TX FIFO head byte (show-ahead)
fifo_rd  out  1  one-cycle pop of the FIFO head
shift_rdy  in  1  shifter can accept a byte / has finished the previous byte
byte_load  out  1  one-cycle strobe; shifter captures tx_byte
tx_byte  out  8  byte presented to the shifter
sending  out  1  packet bytes are in flight
eop  out  1  drive EOP on the bus
tx_done  out  1  one-cycle pulse at packet completion
tx_err  out  1  one-cycle pulse coincident with tx_done when the packet was aborted or overflowed
busy  out  1  state is not IDLE

Behaviour:
- Reset is asynchronous on n_rst low. The state returns to IDLE. All outputs are 0, including tx_byte = 8'h00. pid_q, the payload counter, the CRC and the error flag are all cleared.
- has_payload is defined as (pid_q[1:0] == 2'b11), covering DATA0/1/2/MDATA. Every other PID produces a PID-only packet.
- PID byte format: {~pid_q, pid_q}.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, DRAIN, EOP, DONE.
- IDLE, on tx_start: latch tx_pid, clear the counter, and seed the CRC to 16'hFFFF. Next state is SYNC. The earliest byte_load is therefore 1 cycle after tx_start.
- Each byte state behaves the same way. While shift_rdy = 0, hold the state. When shift_rdy = 1, assert byte_load for exactly one cycle with tx_byte valid in that same cycle, then advance.
- tx_byte is registered and holds its last value between loads.
- SYNC sends SYNC_BYTE, then goes to PID.
- PID sends the PID byte. Next state is DATA if has_payload, otherwise DRAIN.
- DATA, when fifo_empty = 1: go to CRC_LO. No load occurs, and a zero-length payload is legal.
- DATA, when the FIFO is non-empty and shift_rdy = 1: assert byte_load and fifo_rd together, with tx_byte = fifo_rdata. Update the CRC with that byte and increment the counter.
- DATA, when the counter equals MAX_PAYLOAD and fifo_empty = 0: set the error flag and go to DRAIN. The CRC is not sent.
- CRC is USB CRC16: polynomial 0x8005, byte processed LSB-first, final value complemented (crc_out).
- CRC_LO sends crc_out[7:0], then CRC_HI sends crc_out[15:8], then go to DRAIN.
- DRAIN waits for shift_rdy = 1, meaning the last byte has been serialised, then goes to EOP.
- sending is high from the SYNC state through DRAIN, and low in IDLE, EOP and DONE.
- EOP holds eop = 1 for exactly EOP_CYCLES cycles, then goes to DONE.
- DONE pulses tx_done = 1 for one cycle. tx_err equals the error flag in that cycle. Then go to IDLE and clear the flag.
- tx_abort in SYNC, PID, DATA, CRC_LO or CRC_HI: set the error flag and go to DRAIN. No load is issued in that cycle; abort takes priority over a load.
- tx_abort in DRAIN, EOP or DONE: ignored.
- tx_start outside IDLE is ignored, and is not queued.
- tx_pid changes after acceptance have no effect.
- fifo_rd is never asserted outside DATA and never asserted with fifo_empty = 1.

Decomposition:
- Shared package usb_pkg holds:
  - the state enum type;
  - PID constants: PID_DATA0 4'b0011, PID_DATA1 4'b1011, PID_ACK 4'b0010, PID_NAK 4'b1010, PID_STALL 4'b1110;
  - CRC16_POLY and CRC16_INIT.
- Sub-module usb_crc16: inputs clk, n_rst, clear, update, data[7:0]; output crc_out[15:0], already complemented. It is a one-cycle byte-wide combinational update registered on update.

Test Plan:
- ACK packet: tx_start with tx_pid = 4'b0010, shift_rdy tied high -> byte_load sequence 8'h80, 8'hD2. eop is high for 2 cycles, then a single tx_done with tx_err = 0. fifo_rd never asserts.
- DATA0 with empty FIFO: tx_pid = 4'b0011 -> bytes 80, C3, 00, 00 (CRC of an empty payload). tx_done with tx_err = 0.
- DATA1 with payload 00 01 02 03 -> bytes 80, 4B, 00, 01, 02, 03, then two CRC bytes that match a reference-model CRC16. fifo_rd pulses exactly 4 times, each coincident with a payload byte_load.
- Throttling: shift_rdy high 1 cycle in every 8 -> byte_load asserts only in cycles where shift_rdy = 1. Byte order is unchanged and no byte is lost or duplicated.
- Overflow with MAX_PAYLOAD = 4 and 6 bytes queued -> 4 payload loads and no CRC bytes, then EOP, with tx_done and tx_err = 1. 2 bytes remain in the FIFO.
- Abort and reset:
  - tx_abort during the 2nd payload byte -> no further loads, then EOP, with tx_err = 1.
  - n_rst asserted mid-DATA -> all outputs 0 immediately; the next tx_start produces a clean packet.
